// File: rtl/rr_grant_encoder.sv
// rr_grant_encoder: round-robin arbiter over 8 request lines.
// Emits the registered 3-bit index {a,b,c} of the current grantee (a = MSB)
// plus gnt_valid. It feeds the select inputs of a 3-to-8 decoder. The decoder's
// one-hot outputs, qualified by gnt_valid, form the grant bus.
// Each grant runs IDLE -> GRANT -> GAP -> IDLE. The GAP cycle guarantees at
// least two cycles between grants.
// "release" is a reserved word in SystemVerilog, so the grantee-done input
// is named rel.
module rr_grant_encoder #(
  parameter int unsigned HOLD_MAX = 4  // max cycles per grant; 0 = unlimited
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       rel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       gnt_valid
);

  // Hold counter just wide enough to reach HOLD_MAX, never narrower than 1 bit.
  localparam int unsigned CNT_W = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;     // index presented on {a,b,c}
  logic [2:0]         last_q, last_d;   // most recent grantee; search starts after it
  logic [CNT_W-1:0]   cnt_q, cnt_d;     // cycles the current grant has been live
  logic               valid_q, valid_d;

  logic [2:0]         cand;
  logic [2:0]         pick_idx;
  logic               pick_found;
  logic               hold_hit;
  logic               cnt_sat;
  logic               grant_end;

  // Round-robin search: first set request at last+1, last+2, ... (mod 8).
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default at the
    // top, so no path leaves it unassigned and no latch is inferred.
    cand       = '0;
    pick_idx   = last_q;
    pick_found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cand = last_q + 3'(k);  // 3-bit sum wraps 7 -> 0; k = 8 revisits last_q
      if (!pick_found && req[cand]) begin
        pick_idx   = cand;
        pick_found = 1'b1;
      end
    end
  end

  // A bounded grant ends once it has been live HOLD_MAX cycles.
  assign hold_hit  = (HOLD_MAX != 0) && (cnt_q == CNT_W'(HOLD_MAX));
  assign cnt_sat   = (cnt_q == {CNT_W{1'b1}});
  assign grant_end = rel || !req[idx_q] || hold_hit;

  // Next-state and next-output logic for the IDLE / GRANT / GAP sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          idx_d   = pick_idx;
          last_d  = pick_idx;
          cnt_d   = CNT_W'(1);
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end

      GRANT: begin
        if (grant_end) begin
          // The index is left in place through GAP; only gnt_valid drops.
          valid_d = 1'b0;
          state_d = GAP;
        end else if (!cnt_sat) begin
          // Saturation only matters when HOLD_MAX = 0 and the grant is unbounded.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      GAP: begin
        state_d = IDLE;
      end

      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset makes the first search start at index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      last_q  <= 3'd7;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign {a, b, c} = idx_q;
  assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// tb_rr_grant_encoder: random and directed stimulus for rr_grant_encoder.
// A HOLD_MAX=4 instance is compared with a grant-level reference model through a
// scoreboard. A HOLD_MAX=0 instance covers unlimited hold.
`timescale 1ns/1ps
module tb_rr_grant_encoder;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req4 = 8'h00;
  logic       rel4 = 1'b0;
  logic [7:0] req0 = 8'h00;
  logic       rel0 = 1'b0;
  logic       a4, b4, c4, v4;
  logic       a0, b0, c0, v0;

  always #5 clk = ~clk;

  rr_grant_encoder #(.HOLD_MAX(HOLD)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .req       (req4),
    .rel       (rel4),
    .a         (a4),
    .b         (b4),
    .c         (c4),
    .gnt_valid (v4)
  );

  rr_grant_encoder #(.HOLD_MAX(0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .req       (req0),
    .rel       (rel0),
    .a         (a0),
    .b         (b0),
    .c         (c0),
    .gnt_valid (v0)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one finished grant = {index, cycles it was live}.
  typedef struct {
    int idx;
    int len;
  } grant_t;

  grant_t exp_q[$];
  bit     m_valid = 1'b0;  // a grant is live
  int     m_idx   = 0;     // current grantee
  int     m_age   = 0;     // cycles the current grant has been live
  int     m_cool  = 0;     // dead edges left before the next search
  int     m_last  = 7;     // previous grantee
  int     m_abc   = 0;     // index expected on {a,b,c}

  // Model update at every clock edge, using the inputs the DUT samples there.
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_idx   = 0;
      m_age   = 0;
      m_cool  = 0;
      m_last  = 7;
      m_abc   = 0;
    end else if (m_valid) begin
      if (rel4 || !req4[m_idx] || (HOLD != 0 && m_age == HOLD)) begin
        grant_t g;
        g.idx = m_idx;
        g.len = m_age;
        exp_q.push_back(g);
        m_valid = 1'b0;
        m_cool  = 1;
      end else begin
        m_age++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (req4 != 8'h00) begin
      for (int k = 1; k <= 8; k++) begin
        int j;
        j = (m_last + k) % 8;
        if (!m_valid && req4[j]) begin
          m_valid = 1'b1;
          m_idx   = j;
          m_age   = 1;
          m_last  = j;
          m_abc   = j;
        end
      end
    end
  end

  // Monitor: cycle-level compare plus a scoreboard pop at the end of every grant.
  int run_len = 0;
  int run_idx = 0;
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
      exp_q.delete();
    end else begin
      check("valid", v4, m_valid);
      check("abc", {a4, b4, c4}, m_abc);
      if (v4) begin
        if (run_len == 0) run_idx = {a4, b4, c4};
        run_len++;
      end else if (run_len > 0) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", exp_q.size(), 1);
        end else begin
          grant_t g;
          g = exp_q.pop_front();
          check("grant_idx", run_idx, g.idx);
          check("grant_len", run_len, g.len);
        end
        run_len = 0;
      end
    end
  end

  // Pulse rst between edges. Outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check({tag, "_valid"}, v4, 0);
    check({tag, "_abc"}, {a4, b4, c4}, 0);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int k;
    bit prev;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_valid", v4, 0);
    check("rst_abc", {a4, b4, c4}, 0);
    check("rst_valid0", v0, 0);
    rst = 1'b0;

    // A lone request on index 2 is granted at the next edge and held HOLD cycles.
    req4 = 8'h04;
    @(negedge clk);
    check("t1_valid", v4, 1);
    check("t1_abc", {a4, b4, c4}, 2);
    repeat (8) @(negedge clk);

    // Dropping req[idx] ends the grant; the index stays put during GAP.
    req4 = 8'h00;
    repeat (6) @(negedge clk);
    req4 = 8'h08;
    @(negedge clk);
    check("t4_grant", {v4, a4, b4, c4}, 4'b1011);
    req4 = 8'h00;
    @(negedge clk);
    check("t4_gap", {v4, a4, b4, c4}, 4'b0011);

    // Async reset mid-grant, then a full rotation from index 0 with releases.
    repeat (3) @(negedge clk);
    req4 = 8'hFF;
    repeat (2) @(negedge clk);
    check("t5_pre_valid", v4, 1);
    async_reset("t5");
    k    = 0;
    prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (v4 && !prev) begin
        check("t2_order", {a4, b4, c4}, k % 8);
        k++;
      end
      prev = v4;
      rel4 = v4;
    end
    rel4 = 1'b0;

    // Two requesters, no release: HOLD-cycle grants alternate with a 7 -> 0 wrap.
    req4 = 8'h81;
    repeat (30) @(negedge clk);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 60) == 0) begin
        async_reset("rnd");
      end else begin
        case ($urandom_range(0, 3))
          0:       req4 = 8'($urandom);
          1:       req4 = 8'(1 << $urandom_range(0, 7));
          2:       req4 = req4 ^ 8'(1 << $urandom_range(0, 7));
          default: req4 = req4;
        endcase
        rel4 = ($urandom_range(0, 5) == 0);
      end
    end
    req4 = 8'h00;
    rel4 = 1'b0;

    // Unlimited hold: index 5 stays granted; release outside GRANT is ignored.
    req0 = 8'h20;
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      check("t6_hold", {v0, a0, b0, c0}, 4'b1101);
      @(negedge clk);
    end
    req0 = 8'h00;
    @(negedge clk);
    check("t6_drop", {v0, a0, b0, c0}, 4'b0101);
    rel0 = 1'b1;
    @(negedge clk);
    check("t6_gap2", v0, 0);
    req0 = 8'h20;
    @(negedge clk);
    rel0 = 1'b0;
    check("t6_idle_rel", {v0, a0, b0, c0}, 4'b1101);
    repeat (3) @(negedge clk);
    check("t6_regrant_hold", {v0, a0, b0, c0}, 4'b1101);
    req0 = 8'h00;

    // Every finished grant the model predicted must have been observed.
    repeat (10) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
